// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 round driver:
// round constants, core register address map and FSM states.
package sha256_pkg;

  localparam logic [5:0] A_BASE     = 6'd0;
  localparam logic [5:0] W_BASE     = 6'd32;
  localparam logic [5:0] K_BASE     = 6'd36;
  localparam logic [5:0] ROUND_ADDR = 6'd63;

  typedef enum logic [2:0] {
    IDLE, S_TAKE, S_WR, W_TAKE, R_WR, R_GO, RD, OUT
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [7:0] byte_of(
    input logic [31:0] w,
    input logic [1:0]  b
  );
    return w[{b, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/sha256_round_driver.sv
// Sequences state load, 64 W/K injections + round strobes and
// the A..H readback over the round core's byte-wide register port.
module sha256_round_driver
  import sha256_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  bus_addr,
  output logic        bus_rd,
  output logic        bus_stb,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  input  logic        core_ready,
  output logic        busy,
  output logic [5:0]  round
);

  state_e      state_q;
  logic [2:0]  i_q;
  logic [1:0]  b_q;
  logic [5:0]  round_q;
  logic        cap_q;
  logic [31:0] word_q;
  logic [31:0] out_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        busy_q;
  logic        stb_q;
  logic        rd_q;
  logic [5:0]  addr_q;
  logic [7:0]  wdata_q;

  logic [31:0] k_word;
  logic [2:0]  i_d;
  logic [1:0]  b_d;
  logic [1:0]  b_prev;

  assign k_word = K[round_q];
  assign i_d    = i_q + 3'd1;
  assign b_d    = b_q + 2'd1;
  assign b_prev = b_q - 2'd1;

  assign in_ready  = in_ready_q;
  assign out_data  = out_q;
  assign out_valid = out_valid_q;
  assign bus_addr  = addr_q;
  assign bus_rd    = rd_q;
  assign bus_stb   = stb_q;
  assign bus_wdata = wdata_q;
  assign busy      = busy_q;
  assign round     = round_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      i_q         <= '0;
      b_q         <= '0;
      round_q     <= '0;
      cap_q       <= 1'b0;
      word_q      <= '0;
      out_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      stb_q       <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (core_ready) begin
          state_q    <= S_TAKE;
          busy_q     <= 1'b1;
          in_ready_q <= 1'b1;
          i_q        <= '0;
          round_q    <= '0;
        end
        S_TAKE: if (in_valid) begin
          state_q    <= S_WR;
          word_q     <= in_data;
          in_ready_q <= 1'b0;
          b_q        <= '0;
          stb_q      <= 1'b1;
          rd_q       <= 1'b0;
          addr_q     <= A_BASE + {1'b0, i_q, 2'b00};
          wdata_q    <= in_data[7:0];
        end
        S_WR: if (b_q != 2'd3) begin
          b_q     <= b_d;
          addr_q  <= A_BASE + {1'b0, i_q, b_d};
          wdata_q <= byte_of(word_q, b_d);
        end else begin
          stb_q      <= 1'b0;
          in_ready_q <= 1'b1;
          i_q        <= i_d;
          round_q    <= '0;
          state_q    <= (i_q == 3'd7) ? W_TAKE : S_TAKE;
        end
        W_TAKE: if (in_valid) begin
          state_q    <= R_WR;
          word_q     <= in_data;
          in_ready_q <= 1'b0;
          i_q        <= '0;
          stb_q      <= 1'b1;
          addr_q     <= W_BASE;
          wdata_q    <= in_data[7:0];
        end
        // i walks 0..3 over W bytes, then 4..7 over K bytes
        R_WR: if (i_q != 3'd7) begin
          i_q     <= i_d;
          addr_q  <= (i_d[2] ? K_BASE : W_BASE) + {4'd0, i_d[1:0]};
          wdata_q <= i_d[2] ? byte_of(k_word, i_d[1:0])
                            : byte_of(word_q, i_d[1:0]);
        end else begin
          state_q <= R_GO;
          addr_q  <= ROUND_ADDR;
          wdata_q <= '0;
        end
        R_GO: begin
          round_q <= round_q + 6'd1;
          i_q     <= '0;
          b_q     <= '0;
          cap_q   <= 1'b0;
          if (round_q == 6'd63) begin
            state_q <= RD;
            rd_q    <= 1'b1;
            addr_q  <= A_BASE;
          end else begin
            state_q    <= W_TAKE;
            stb_q      <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        // byte from the previous issue lands while the next one goes out
        RD: if (!cap_q) begin
          if (b_q != 2'd0) word_q[{b_prev, 3'b000} +: 8] <= bus_rdata;
          if (b_q == 2'd3) begin
            cap_q <= 1'b1;
            stb_q <= 1'b0;
          end else begin
            b_q    <= b_d;
            addr_q <= A_BASE + {1'b0, i_q, b_d};
          end
        end else begin
          cap_q       <= 1'b0;
          rd_q        <= 1'b0;
          out_q       <= {bus_rdata, word_q[23:0]};
          out_valid_q <= 1'b1;
          state_q     <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (i_q != 3'd7) begin
            state_q <= RD;
            i_q     <= i_d;
            b_q     <= '0;
            stb_q   <= 1'b1;
            rd_q    <= 1'b1;
            addr_q  <= A_BASE + {1'b0, i_d, 2'b00};
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_round_driver.sv
// Bench for sha256_round_driver: byte-port round core model,
// reference SHA-256 compression and a bus write-log checker.
`timescale 1ns/1ps
module tb_sha256_round_driver;

  typedef logic [7:0][31:0]  st_t;
  typedef logic [63:0][31:0] ws_t;
  typedef struct packed {
    logic [5:0]  a;
    logic [7:0]  d;
    int unsigned c;
  } wr_t;
  typedef struct {
    int         idx;
    logic [5:0] a;
    logic [7:0] d;
    bit         cd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  bus_addr;
  logic        bus_rd;
  logic        bus_stb;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = '0;
  logic        core_ready;
  logic        busy;
  logic [5:0]  round;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_round_driver dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_stb(bus_stb),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .core_ready(core_ready), .busy(busy), .round(round)
  );

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic st_t one_round(input st_t s, input logic [31:0] k,
                                    input logic [31:0] w);
    logic [31:0] t1, t2;
    st_t r;
    t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
         + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
         + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    r[0] = t1 + t2; r[1] = s[0]; r[2] = s[1]; r[3] = s[2];
    r[4] = s[3] + t1; r[5] = s[4]; r[6] = s[5]; r[7] = s[6];
    return r;
  endfunction

  function automatic st_t compress(input st_t iv, input ws_t w);
    st_t s;
    s = iv;
    for (int t = 0; t < 64; t++) s = one_round(s, KT[t], w[t]);
    return s;
  endfunction

  function automatic ws_t expand(input logic [15:0][31:0] m);
    ws_t w;
    logic [31:0] s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) begin
      s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    return w;
  endfunction

  // Round core model: byte-addressed registers, one-cycle read latency
  logic [31:0] creg [16];
  st_t cs;
  always @(posedge clk) begin
    if (bus_stb && bus_rd) begin
      bus_rdata <= creg[bus_addr[5:2]][{bus_addr[1:0], 3'b000} +: 8];
    end else if (bus_stb && bus_addr == 6'd63) begin
      for (int k = 0; k < 8; k++) cs[k] = creg[k];
      cs = one_round(cs, creg[9], creg[8]);
      for (int k = 0; k < 8; k++) creg[k] <= cs[k];
    end else if (bus_stb && bus_addr < 6'd40) begin
      creg[bus_addr[5:2]][{bus_addr[1:0], 3'b000} +: 8] <= bus_wdata;
    end
  end

  wr_t wlog[$];
  always @(negedge clk)
    if (bus_stb && !bus_rd) wlog.push_back('{bus_addr, bus_wdata, cyc});

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_block(input st_t st, input ws_t w, input int gap,
                           input int rdy_pct, input bit stall,
                           output st_t res);
    res = '0;
    wlog.delete();
    fork
      begin
        int pb;
        pb = 0;
        for (int k = 0; k < 72 && pb < 4000; k++) begin
          while ($urandom_range(99) < gap) begin
            in_valid = 1'b0;
            @(negedge clk);
          end
          in_data  = (k < 8) ? st[k] : w[k-8];
          in_valid = 1'b1;
          while (!in_ready && pb < 4000) begin
            @(negedge clk);
            pb++;
          end
          @(negedge clk);
        end
        in_valid = 1'b0;
        chk("in_timeout", pb < 4000, 1);
      end
      begin
        int cb;
        logic [31:0] hold;
        bit stable;
        cb = 0;
        for (int j = 0; j < 8; j++) begin
          while (!out_valid && cb < 4000) begin
            @(negedge clk);
            cb++;
          end
          if (cb >= 4000) break;
          if (stall && j == 0) begin
            hold = out_data;
            stable = 1'b1;
            out_ready = 1'b0;
            for (int n = 0; n < 100; n++) begin
              @(negedge clk);
              if (!out_valid || out_data !== hold || bus_stb) stable = 1'b0;
            end
            chk("stall_hold", stable, 1);
          end
          while ($urandom_range(99) >= rdy_pct) begin
            out_ready = 1'b0;
            @(negedge clk);
          end
          res[j] = out_data;
          out_ready = 1'b1;
          @(negedge clk);
          out_ready = 1'b0;
        end
        chk("out_timeout", cb < 4000, 1);
      end
    join
  endtask

  task automatic check_log(input st_t st, input ws_t w, input string nm);
    int bad, n;
    bad = -1;
    n = 0;
    if (wlog.size() != 608) bad = -2;
    else begin
      for (int i = 0; i < 8; i++)
        for (int b = 0; b < 4; b++) begin
          if (bad < 0 && (wlog[n].a != 6'(4*i + b) ||
              wlog[n].d != st[i][8*b +: 8])) bad = n;
          n++;
        end
      for (int r = 0; r < 64; r++) begin
        for (int b = 0; b < 4; b++) begin
          if (bad < 0 && (wlog[n].a != 6'(32 + b) ||
              wlog[n].d != w[r][8*b +: 8])) bad = n;
          n++;
        end
        for (int b = 0; b < 4; b++) begin
          if (bad < 0 && (wlog[n].a != 6'(36 + b) ||
              wlog[n].d != KT[r][8*b +: 8])) bad = n;
          n++;
        end
        if (bad < 0 && wlog[n].a != 6'd63) bad = n;
        n++;
      end
    end
    chk({nm, "_wrlog"}, bad, -1);
  endtask

  task automatic check_digest(input st_t got, input st_t exp,
                              input string nm);
    for (int j = 0; j < 8; j++)
      chk($sformatf("%s_word%0d", nm, j), got[j], exp[j]);
  endtask

  function automatic st_t rand_st();
    st_t s;
    for (int k = 0; k < 8; k++) s[k] = $urandom();
    return s;
  endfunction

  function automatic ws_t rand_ws();
    ws_t w;
    for (int k = 0; k < 64; k++) w[k] = $urandom();
    return w;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    st_t iv, st, res;
    ws_t w;
    logic [15:0][31:0] m;
    vec_t tbl [13];
    int k, n;

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    core_ready = 1'b1; rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", {in_ready, out_valid, out_data, bus_stb, bus_rd,
        bus_addr, bus_wdata, busy, round}, 0);
    rst = 1'b0;
    #1 chk("ready_not_yet", in_ready, 0);
    @(negedge clk);
    chk("ready_rise", {in_ready, busy}, 2'b11);

    iv[0] = 32'h6a09e667; iv[1] = 32'hbb67ae85;
    iv[2] = 32'h3c6ef372; iv[3] = 32'ha54ff53a;
    iv[4] = 32'h510e527f; iv[5] = 32'h9b05688c;
    iv[6] = 32'h1f83d9ab; iv[7] = 32'h5be0cd19;
    m = '0;
    m[0] = 32'h61626380;
    m[15] = 32'h00000018;
    w = expand(m);
    run_block(iv, w, 0, 100, 1'b0, res);

    tbl[0]  = '{0,  6'd0,  8'h67, 1'b1};
    tbl[1]  = '{1,  6'd1,  8'he6, 1'b1};
    tbl[2]  = '{2,  6'd2,  8'h09, 1'b1};
    tbl[3]  = '{3,  6'd3,  8'h6a, 1'b1};
    tbl[4]  = '{32, 6'd32, 8'h80, 1'b1};
    tbl[5]  = '{33, 6'd33, 8'h63, 1'b1};
    tbl[6]  = '{34, 6'd34, 8'h62, 1'b1};
    tbl[7]  = '{35, 6'd35, 8'h61, 1'b1};
    tbl[8]  = '{36, 6'd36, 8'h98, 1'b1};
    tbl[9]  = '{37, 6'd37, 8'h2f, 1'b1};
    tbl[10] = '{38, 6'd38, 8'h8a, 1'b1};
    tbl[11] = '{39, 6'd39, 8'h42, 1'b1};
    tbl[12] = '{40, 6'd63, 8'h00, 1'b0};
    chk("abc_logsize", wlog.size() > 40, 1);
    if (wlog.size() > 40) begin
      for (int t = 0; t < 13; t++)
        chk($sformatf("abc_wr%0d", tbl[t].idx),
            {wlog[tbl[t].idx].a, tbl[t].cd ? wlog[tbl[t].idx].d : 8'h00},
            {tbl[t].a, tbl[t].d});
      chk("state_wr_consec", wlog[3].c - wlog[0].c, 3);
      chk("wk_wr_consec", wlog[39].c - wlog[32].c, 7);
      chk("round_after_k", wlog[40].c - wlog[39].c, 1);
    end
    chk("abc_a", res[0], 32'h506e3058);
    chk("abc_h0", res[0] + iv[0], 32'hba7816bf);
    check_digest(res, compress(iv, w), "abc");
    check_log(iv, w, "abc");

    st = rand_st(); w = rand_ws();
    run_block(st, w, 30, 70, 1'b1, res);
    check_digest(res, compress(st, w), "stall");
    check_log(st, w, "stall");

    for (int r = 0; r < 3; r++) begin
      st = rand_st(); w = rand_ws();
      run_block(st, w, 10 * r, 100 - 20 * r, 1'b0, res);
      check_digest(res, compress(st, w), $sformatf("rand%0d", r));
      check_log(st, w, $sformatf("rand%0d", r));
    end

    st = rand_st(); w = rand_ws();
    k = 0; n = 0;
    while (round != 6'd30 && n < 3000) begin
      in_data  = (k < 8) ? st[k] : w[k-8];
      in_valid = 1'b1;
      if (in_ready) k++;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    chk("reach_round30", n < 3000, 1);
    rst = 1'b1;
    #1 chk("rst_mid_async", {busy, round, in_ready, bus_stb, out_valid}, 0);
    @(negedge clk);
    chk("rst_mid_held", {busy, round, in_ready, bus_stb, bus_rd}, 0);
    rst = 1'b0;
    st = rand_st(); w = rand_ws();
    run_block(st, w, 20, 60, 1'b0, res);
    check_digest(res, compress(st, w), "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_driver.md
# sha256_round_driver

Bus-initiator sequencer for the SHA-256 round core's byte-wide register-file port. It accepts a 32-bit word stream: 8 chaining-state words followed by 64 message-schedule words W0..W63. It writes the state into A..H and injects W_t and K_t before each round strobe, runs all 64 rounds, then reads A..H back out as 32-bit words. It sits between an on-chip message scheduler or host FIFO and the round core.

## Interface
Parameters:
- none; K constants and bus address map live in `sha256_pkg`.

Ports:
- `clk` in 1 — single clock.
- `rst` in 1 — asynchronous reset, active-high.
- `in_data` in 32 — state or W word.
- `in_valid` in 1 — `in_data` valid.
- `in_ready` out 1 — word accepted on clock edge when `in_valid && in_ready`.
- `out_data` out 32 — result word (A first, H last).
- `out_valid` out 1 — `out_data` valid, held until taken.
- `out_ready` in 1 — consumer accepts on edge when both high.
- `bus_addr` out 6 — core register byte address (to core addr pins).
- `bus_rd` out 1 — 1 = read, 0 = write (to core write-enable pin; core drives data when 1).
- `bus_stb` out 1 — per-cycle access strobe (to core strobe pin).
- `bus_wdata` out 8 — write byte (to core data-in).
- `bus_rdata` in 8 — read byte (from core data-out).
- `core_ready` in 1 — core out of reset.
- `busy` out 1 — high in every state except IDLE.
- `round` out 6 — current round index.

## Operation
- Address map: byte address 4r+b = register r, byte b (b=0 is LSB). r=0..7 is A..H, r=8 is W, r=9 is K. Address 63 with write = one compression round.
- FSM states and transitions:
  - IDLE → S_TAKE once `core_ready`=1.
  - S_TAKE (`in_ready`=1) → S_WR on handshake.
  - S_WR: 4 cycles, byte b of the latched word to addr 4i+b. Then → S_TAKE for i<7, else → W_TAKE.
  - W_TAKE (`in_ready`=1) → R_WR on handshake.
  - R_WR: 8 cycles. W bytes go to addr 32..35, then K[round] bytes to 36..39.
  - R_GO: 1 cycle with addr 63, write. `round`++. → W_TAKE while round<63, else → RD.
  - RD: 4 read issues, addr 4i+b, then 1 capture cycle. → OUT.
  - OUT (`out_valid`=1) → RD for i<7 on handshake, else → IDLE.
- Counters: word index i (3b), byte index b (2b), round (6b). All wrap naturally; each is cleared on entry to its phase.
- `in_valid` outside S_TAKE/W_TAKE is ignored; `in_ready`=0 there.
- `out_ready` low in OUT stalls indefinitely; the bus is idle (`bus_stb`=0) while stalled.
- The block does no final state addition; the consumer adds the chaining value.
- Reset mid-operation: return to IDLE, counters cleared. The core's registers are not touched. The next block fully rewrites A..H, W and K, so stale core contents are harmless.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_data`=0, `bus_stb`=0, `bus_rd`=0, `bus_addr`=0, `bus_wdata`=0, `busy`=0, `round`=0.
- All bus outputs are registered. In each S_WR, R_WR or R_GO cycle, `bus_stb`=1 and `bus_rd`=0 for exactly that cycle.
- Read pipeline: a read issued in cycle c (`bus_stb`=1, `bus_rd`=1) returns data on `bus_rdata` in cycle c+1. The returning byte is captured at the end of c+1. The next issue overlaps it.
- `bus_rd` stays 1 through all of RD including the capture cycle, because the core's output enable follows it. `bus_rd` returns to 0 in OUT.
- Minimum cycles per block:
  - State load: 8×(1+4) = 40.
  - Rounds: 64×(1+8+1) = 640.
  - Readback: 8×(5+1) = 48.
- `out_data` updates only on entry to OUT and is stable while `out_valid`=1.

## Structure
- `sha256_pkg`:
  - 64-entry K constant array.
  - Address constants: A_BASE=0, W_BASE=32, K_BASE=36, ROUND_ADDR=63.
  - FSM state enum.
- K lookup is a combinational case on `round`. It is inlined; no sub-module is needed.

## Test plan
- Reset with `core_ready`=1 and `rst` held → all outputs match the reset values. On release, `in_ready` rises in the next cycle.
- Feed state word 0x6a09e667 → bus writes 0x67, 0xe6, 0x09, 0x6a to addr 0..3 in 4 consecutive cycles.
- Feed W0=0x61626380 at round 0 → addr 32..35 get 0x80, 0x63, 0x62, 0x61. Addr 36..39 get 0x98, 0x2f, 0x8a, 0x42 (K0=0x428a2f98). Then one write to addr 63.
- Full "abc" block against the real round core (IV state + 64-word schedule) → first `out_data` = 0x506e3058. Adding IV a gives 0xba7816bf.
- Hold `out_ready`=0 for 100 cycles in OUT → `out_valid` and `out_data` stable, `bus_stb`=0. Then the remaining 7 words drain correctly.
- Assert `rst` during round 30 → IDLE next cycle, `round`=0, `busy`=0. A following full block still produces the correct digest.
